// File: rtl/exc_ctrl_if.sv
// Signal bundle between decode/CP0 (master side) and the exception sequencer exc_ctrl (slave side).
interface exc_ctrl_if;
  logic [31:0] pc_i;
  logic        syscall_i;
  logic        break_i;
  logic        teq_i;
  logic        eret_i;
  logic [31:0] status_i;
  logic [31:0] exc_addr_i;
  logic        exception_o;
  logic        eret_o;
  logic [1:0]  cause_o;
  logic [31:0] epc_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        in_handler_o;

  modport master (
    output pc_i, syscall_i, break_i, teq_i, eret_i, status_i, exc_addr_i,
    input  exception_o, eret_o, cause_o, epc_o, redirect_o, redirect_pc_o, in_handler_o
  );

  modport slave (
    input  pc_i, syscall_i, break_i, teq_i, eret_i, status_i, exc_addr_i,
    output exception_o, eret_o, cause_o, epc_o, redirect_o, redirect_pc_o, in_handler_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception sequencer ahead of CP0: admits, prioritises and sequences traps, with no nesting until eret.
// Optional external interrupt input is enabled by defining EXC_EXT_INT_EN.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic       clk,
  input  logic       rst,
`ifdef EXC_EXT_INT_EN
  input  logic       ext_int_i,
`endif
  exc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [3:0]  pending_r, pending_s, accepted_s, pend_all_s, win_s;
  logic [31:0] pc_r [4];
  logic [1:0]  win_idx_s, win_cause_s;
  logic [31:0] win_epc_s;
  logic        take_s, ext_req_s;
  logic        exception_r, eret_r, redirect_r, in_handler_r;
  logic        exception_s, eret_s, redirect_s, in_handler_s;
  logic [1:0]  cause_r, cause_s;
  logic [31:0] epc_r, epc_s, redirect_pc_r, redirect_pc_s;
  logic        unused_s;

`ifdef EXC_EXT_INT_EN
  logic [1:0] ext_sync_r;
  // Two-flop synchroniser for the asynchronous interrupt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_sync_r <= 2'b00;
    end else begin
      ext_sync_r <= {ext_sync_r[0], ext_int_i};
    end
  end
  assign ext_req_s = ext_sync_r[1];
  assign unused_s  = ^{bus.status_i[31:5]};
`else
  assign ext_req_s = 1'b0;
  assign unused_s  = ^{bus.status_i[31:4]};
`endif

  // Admission filter: a request only survives if globally and individually enabled.
  always_comb begin
    accepted_s = 4'b0000;
    if (bus.status_i[0]) begin
      accepted_s[0] = bus.syscall_i & bus.status_i[1];
      accepted_s[1] = bus.break_i   & bus.status_i[2];
      accepted_s[2] = bus.teq_i     & bus.status_i[3];
      accepted_s[3] = ext_req_s     & bus.status_i[4];
    end else begin
      accepted_s = 4'b0000;
    end
  end

  assign pend_all_s = pending_r | accepted_s;

  // Fixed priority teq > break > ext > syscall over stored and newly accepted requests.
  always_comb begin
    win_s       = 4'b0000;
    win_idx_s   = 2'd0;
    win_cause_s = 2'b00;
    if (pend_all_s[2]) begin
      win_s = 4'b0100; win_idx_s = 2'd2; win_cause_s = 2'b11;
    end else if (pend_all_s[1]) begin
      win_s = 4'b0010; win_idx_s = 2'd1; win_cause_s = 2'b01;
    end else if (pend_all_s[3]) begin
      win_s = 4'b1000; win_idx_s = 2'd3; win_cause_s = 2'b10;
    end else if (pend_all_s[0]) begin
      win_s = 4'b0001; win_idx_s = 2'd0; win_cause_s = 2'b00;
    end else begin
      win_s = 4'b0000; win_idx_s = 2'd0; win_cause_s = 2'b00;
    end
  end

  // An older pending entry keeps its own PC; a fresh one uses the PC in decode now.
  assign win_epc_s = pending_r[win_idx_s] ? pc_r[win_idx_s] : bus.pc_i;
  assign take_s    = (state_r == ST_IDLE) && (|pend_all_s);
  assign pending_s = pend_all_s & ~(take_s ? win_s : 4'b0000);

  // Pending bits and per-bit PCs; a repeat of an already pending kind merges into it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= 4'b0000;
      for (int k = 0; k < 4; k++) pc_r[k] <= 32'h0000_0000;
    end else begin
      pending_r <= pending_s;
      for (int k = 0; k < 4; k++) begin
        if (accepted_s[k] && !pending_r[k]) pc_r[k] <= bus.pc_i;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    next_state_s = take_s ? ST_ENTER : ST_IDLE;
      ST_ENTER:   next_state_s = ST_HANDLER;
      ST_HANDLER: next_state_s = bus.eret_i ? ST_IDLE : ST_HANDLER;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Output values for the next cycle; data outputs hold when nothing is issued.
  always_comb begin
    exception_s   = 1'b0;
    eret_s        = 1'b0;
    redirect_s    = 1'b0;
    cause_s       = cause_r;
    epc_s         = epc_r;
    redirect_pc_s = redirect_pc_r;
    in_handler_s  = (next_state_s == ST_HANDLER);
    if (take_s) begin
      exception_s   = 1'b1;
      redirect_s    = 1'b1;
      cause_s       = win_cause_s;
      epc_s         = win_epc_s;
      redirect_pc_s = EXC_VECTOR;
    end else if ((state_r == ST_HANDLER) && bus.eret_i) begin
      eret_s        = 1'b1;
      redirect_s    = 1'b1;
      redirect_pc_s = bus.exc_addr_i;
    end else begin
      exception_s   = 1'b0;
      eret_s        = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exception_r   <= 1'b0;
      eret_r        <= 1'b0;
      redirect_r    <= 1'b0;
      in_handler_r  <= 1'b0;
      cause_r       <= 2'b00;
      epc_r         <= 32'h0000_0000;
      redirect_pc_r <= 32'h0000_0000;
    end else begin
      exception_r   <= exception_s;
      eret_r        <= eret_s;
      redirect_r    <= redirect_s;
      in_handler_r  <= in_handler_s;
      cause_r       <= cause_s;
      epc_r         <= epc_s;
      redirect_pc_r <= redirect_pc_s;
    end
  end

  assign bus.exception_o   = exception_r;
  assign bus.eret_o        = eret_r;
  assign bus.redirect_o    = redirect_r;
  assign bus.in_handler_o  = in_handler_r;
  assign bus.cause_o       = cause_r;
  assign bus.epc_o         = epc_r;
  assign bus.redirect_pc_o = redirect_pc_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised self-checking bench for exc_ctrl against a trap-list reference model.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst;
`ifdef EXC_EXT_INT_EN
  logic ext_int;
`endif

  exc_ctrl_if bus();

  exc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EXC_EXT_INT_EN
    .ext_int_i (ext_int),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: kinds 0 syscall, 1 break, 2 teq, 3 ext; mode 0 idle, 1 enter, 2 handler.
  bit          m_pend [4];
  logic [31:0] m_pc   [4];
  int          m_mode;
  bit          m_s0, m_s1;
  int          prio     [4] = '{2, 1, 3, 0};
  logic [1:0]  cause_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic        e_exc, e_eret, e_redir, e_inh;
  logic [1:0]  e_cause;
  logic [31:0] e_epc, e_rpc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_pend[k] = 1'b0; m_pc[k] = 32'h0; end
    m_mode = 0; m_s0 = 1'b0; m_s1 = 1'b0;
    e_exc = 1'b0; e_eret = 1'b0; e_redir = 1'b0; e_inh = 1'b0;
    e_cause = 2'b00; e_epc = 32'h0; e_rpc = 32'h0;
  endtask

  task automatic model_step();
    bit req [4];
    int w;
    req[0] = bus.syscall_i; req[1] = bus.break_i; req[2] = bus.teq_i;
`ifdef EXC_EXT_INT_EN
    req[3] = m_s1; m_s1 = m_s0; m_s0 = ext_int;
`else
    req[3] = 1'b0;
`endif
    for (int k = 0; k < 4; k++)
      if (req[k] && bus.status_i[0] && bus.status_i[k+1] && !m_pend[k]) begin
        m_pend[k] = 1'b1; m_pc[k] = bus.pc_i;
      end
    e_exc = 1'b0; e_eret = 1'b0; e_redir = 1'b0;
    if (m_mode == 0) begin
      w = -1;
      for (int j = 0; j < 4; j++) if (w < 0 && m_pend[prio[j]]) w = prio[j];
      if (w >= 0) begin
        m_pend[w] = 1'b0; e_exc = 1'b1; e_redir = 1'b1; e_rpc = VEC;
        e_cause = cause_of[w]; e_epc = m_pc[w]; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (bus.eret_i) begin
      e_eret = 1'b1; e_redir = 1'b1; e_rpc = bus.exc_addr_i; m_mode = 0;
    end
    e_inh = (m_mode == 2);
  endtask

  task automatic compare_all();
    check_val("exception", {31'b0, bus.exception_o}, {31'b0, e_exc});
    check_val("eret",      {31'b0, bus.eret_o},      {31'b0, e_eret});
    check_val("redirect",  {31'b0, bus.redirect_o},  {31'b0, e_redir});
    check_val("in_handler",{31'b0, bus.in_handler_o},{31'b0, e_inh});
    check_val("cause",     {30'b0, bus.cause_o},     {30'b0, e_cause});
    check_val("epc",       bus.epc_o,                e_epc);
    check_val("redir_pc",  bus.redirect_pc_o,        e_rpc);
  endtask

  // One clock: predict, let the edge happen, compare mid-cycle, then drop single-cycle pulses.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    bus.syscall_i = 1'b0; bus.break_i = 1'b0; bus.teq_i = 1'b0; bus.eret_i = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (m_mode != 0 || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]); i++) begin
      bus.eret_i = 1'b1;
      cycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.pc_i = 32'h0; bus.syscall_i = 1'b0; bus.break_i = 1'b0; bus.teq_i = 1'b0;
    bus.eret_i = 1'b0; bus.status_i = 32'h0; bus.exc_addr_i = 32'h0;
`ifdef EXC_EXT_INT_EN
    ext_int = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Basic syscall entry.
    bus.status_i = 32'h3; bus.pc_i = 32'h0040_0100; bus.syscall_i = 1'b1;
    cycle();
    check_val("t1_exc",   {31'b0, bus.exception_o}, 32'd1);
    check_val("t1_cause", {30'b0, bus.cause_o}, 32'd0);
    check_val("t1_epc",   bus.epc_o, 32'h0040_0100);
    check_val("t1_vec",   bus.redirect_pc_o, 32'h0040_0004);
    cycle();
    check_val("t1_inh",   {31'b0, bus.in_handler_o}, 32'd1);
    drain();

    // Masked syscall is dropped for good.
    bus.status_i = 32'h1; bus.syscall_i = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.status_i = 32'h3;
      cycle();
      check_val("t2_masked", {31'b0, bus.exception_o}, 32'd0);
    end

    // break and teq together: teq first, break afterwards with its own PC.
    bus.status_i = 32'hF; bus.pc_i = 32'h0040_0200; bus.break_i = 1'b1; bus.teq_i = 1'b1;
    cycle();
    check_val("t3_teq", {30'b0, bus.cause_o}, 32'd3);
    bus.pc_i = 32'h0040_0300;
    cycle();
    bus.eret_i = 1'b1; bus.exc_addr_i = 32'h0040_0204;
    cycle();
    check_val("t3_eret", {31'b0, bus.eret_o}, 32'd1);
    cycle();
    check_val("t3_brk_exc", {31'b0, bus.exception_o}, 32'd1);
    check_val("t3_brk", {30'b0, bus.cause_o}, 32'd1);
    check_val("t3_brk_epc", bus.epc_o, 32'h0040_0200);
    cycle();
    drain();

    // teq arriving with eret in the handler.
    bus.syscall_i = 1'b1; cycle(); cycle();
    bus.teq_i = 1'b1; bus.eret_i = 1'b1; bus.exc_addr_i = 32'h0040_0104;
    cycle();
    check_val("t4_eret", {31'b0, bus.eret_o}, 32'd1);
    check_val("t4_rpc", bus.redirect_pc_o, 32'h0040_0104);
    cycle();
    check_val("t4_exc", {31'b0, bus.exception_o}, 32'd1);
    check_val("t4_cause", {30'b0, bus.cause_o}, 32'd3);

    // Reset while in ENTER.
    drain();
    bus.syscall_i = 1'b1; cycle();
    async_reset();
    check_val("t5_inh", {31'b0, bus.in_handler_o}, 32'd0);
    cycle();

`ifdef EXC_EXT_INT_EN
    begin
      int lat;
      bus.status_i = 32'h11; ext_int = 1'b1; lat = 0;
      for (int i = 0; i < 5 && !bus.exception_o; i++) begin cycle(); lat++; end
      check_val("t6_lat_ok", {31'b0, (lat <= 3)}, 32'd1);
      check_val("t6_cause", {30'b0, bus.cause_o}, 32'd2);
      ext_int = 1'b0;
      repeat (3) cycle();
      drain();
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.pc_i = $urandom; bus.exc_addr_i = $urandom; bus.status_i = $urandom;
      if ($urandom_range(0, 4) != 0) bus.status_i[0] = 1'b1;
      bus.syscall_i = ($urandom_range(0, 5) == 0);
      bus.break_i   = ($urandom_range(0, 5) == 0);
      bus.teq_i     = ($urandom_range(0, 5) == 0);
      bus.eret_i    = ($urandom_range(0, 2) == 0);
`ifdef EXC_EXT_INT_EN
      if ($urandom_range(0, 9) == 0) ext_int = ~ext_int;
`endif
      cycle();
      if (i % 700 == 350) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
